// File: rtl/fighter_motion.sv
// fighter_motion
//   Position/physics engine for one on-screen fighter. The keyboard keycode is
//   sampled once per video frame. Each frame the fighter walks left or right and
//   runs a ground / rising / falling jump machine with gravity. The block holds
//   the fighter's top-left corner and reports whether the current beam position
//   lies inside the sprite box.
//
// Ports
//   Clk         in   1   system clock
//   Reset       in   1   asynchronous active-high reset
//   frame_clk   in   1   frame strobe (vsync derived); its rising edge is one frame
//   keycode     in   8   current keycode, 0 = no key
//   DrawX       in   10  current pixel column
//   DrawY       in   10  current pixel row
//   is_fighter  out  1   beam position is inside the sprite box
//   Fighter_X   out  10  top-left X
//   Fighter_Y   out  10  top-left Y
//   airborne    out  1   fighter is rising or falling
//
// Configuration macro
//   FIGHTER_DOUBLE_JUMP_EN : allows one extra jump while airborne.

module fighter_motion #(
  parameter int unsigned X_START   = 100,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 48,
  parameter int unsigned GROUND_Y  = 380,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned JUMP_VEL  = 12,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned MAX_FALL  = 15,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_JUMP  = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_fighter,
  output logic [9:0] Fighter_X,
  output logic [9:0] Fighter_Y,
  output logic       airborne
);

  localparam int unsigned Y_GROUND    = GROUND_Y - HEIGHT;
  localparam int unsigned X_RIGHT_LIM = X_MAX - WIDTH + 1;

  localparam logic [1:0] GROUND  = 2'd0;
  localparam logic [1:0] RISING  = 2'd1;
  localparam logic [1:0] FALLING = 2'd2;

  logic       frame_sync_reg, frame_prev_reg;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic [4:0] vy_reg, vy_next;
  logic [1:0] state_reg, state_next;
  logic       armed_reg, armed_next;
  logic       tick;
  logic       jump_key;
  logic       launch;
  logic       relaunch;

  // Frame edge detect: one tick per rising edge of frame_clk as seen in Clk.
  assign tick     = frame_sync_reg & ~frame_prev_reg;
  assign jump_key = (keycode == KEY_JUMP);

`ifdef FIGHTER_DOUBLE_JUMP_EN
  logic dj_used_reg, dj_used_next;
  assign relaunch = (state_reg != GROUND) & jump_key & armed_reg & ~dj_used_reg;
`else
  assign relaunch = 1'b0;
`endif

  assign launch = ((state_reg == GROUND) & jump_key & armed_reg) | relaunch;

  // Horizontal motion, compared in 11 bits so moving left never wraps.
  logic [10:0] x_ext;
  assign x_ext = {1'b0, x_reg};

  always_comb begin
    x_next = x_reg;
    if (keycode == KEY_LEFT) begin
      if (x_ext < 11'(X_MIN + WALK_STEP)) x_next = 10'(X_MIN);
      else                                x_next = x_reg - 10'(WALK_STEP);
    end else if (keycode == KEY_RIGHT) begin
      if (x_ext + 11'(WALK_STEP) > 11'(X_RIGHT_LIM)) x_next = 10'(X_RIGHT_LIM);
      else                                            x_next = x_reg + 10'(WALK_STEP);
    end
  end

  // Vertical motion. vy is a magnitude; the state gives its direction.
  logic [10:0] y_ext, y_fall;
  logic [5:0]  vy_inc;
  logic [4:0]  vy_fall, vy_dec;

  assign y_ext   = {1'b0, y_reg};
  assign vy_dec  = vy_reg - 5'(GRAVITY);
  assign vy_inc  = {1'b0, vy_reg} + 6'(GRAVITY);
  assign vy_fall = (vy_inc > 6'(MAX_FALL)) ? 5'(MAX_FALL) : vy_inc[4:0];
  assign y_fall  = y_ext + {6'b0, vy_fall};

  always_comb begin
    y_next     = y_reg;
    vy_next    = vy_reg;
    state_next = state_reg;
    if (launch) begin
      // Launch (or airborne relaunch) keeps Y this frame and loads the speed.
      state_next = RISING;
      vy_next    = 5'(JUMP_VEL);
    end else begin
      case (state_reg)
        GROUND: ;
        RISING: begin
          if (y_ext < {6'b0, vy_reg} + 11'(Y_MIN)) begin
            // Would pass through the ceiling: pin to it and start falling.
            y_next     = 10'(Y_MIN);
            vy_next    = 5'd0;
            state_next = FALLING;
          end else begin
            y_next  = y_reg - {5'b0, vy_reg};
            vy_next = vy_dec;
            if (vy_dec == 5'd0) state_next = FALLING;
          end
        end
        FALLING: begin
          if (y_fall >= 11'(Y_GROUND)) begin
            y_next     = 10'(Y_GROUND);
            vy_next    = 5'd0;
            state_next = GROUND;
          end else begin
            y_next  = y_fall[9:0];
            vy_next = vy_fall;
          end
        end
        default: state_next = FALLING;  // unused encoding: drop back to the floor
      endcase
    end
  end

  // Re-arm on any frame without the jump key so a held key cannot auto-repeat.
  always_comb begin
    armed_next = armed_reg;
    if (launch)         armed_next = 1'b0;
    else if (!jump_key) armed_next = 1'b1;
  end

`ifdef FIGHTER_DOUBLE_JUMP_EN
  always_comb begin
    dj_used_next = dj_used_reg;
    if (relaunch)                                      dj_used_next = 1'b1;
    else if (state_reg != GROUND && state_next == GROUND) dj_used_next = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     dj_used_reg <= 1'b0;
    else if (tick) dj_used_reg <= dj_used_next;
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync_reg <= 1'b0;
      frame_prev_reg <= 1'b0;
      x_reg          <= 10'(X_START);
      y_reg          <= 10'(Y_GROUND);
      vy_reg         <= 5'd0;
      state_reg      <= GROUND;
      armed_reg      <= 1'b1;
    end else begin
      frame_sync_reg <= frame_clk;
      frame_prev_reg <= frame_sync_reg;
      if (tick) begin
        x_reg     <= x_next;
        y_reg     <= y_next;
        vy_reg    <= vy_next;
        state_reg <= state_next;
        armed_reg <= armed_next;
      end
    end
  end

  assign Fighter_X = x_reg;
  assign Fighter_Y = y_reg;
  assign airborne  = (state_reg != GROUND);

  logic [10:0] dx_ext, dy_ext, fy_ext;
  assign dx_ext = {1'b0, DrawX};
  assign dy_ext = {1'b0, DrawY};
  assign fy_ext = {1'b0, y_reg};

  assign is_fighter = (dx_ext >= x_ext) && (dx_ext < x_ext + 11'(WIDTH)) &&
                      (dy_ext >= fy_ext) && (dy_ext < fy_ext + 11'(HEIGHT));

endmodule

// File: tb/tb_fighter_motion.sv
// tb_fighter_motion
//   Directed and randomized stimulus for fighter_motion, checked against a
//   behavioural model that tracks position and a signed vertical velocity
//   (positive = upward) rather than a state encoding.

module tb_fighter_motion;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] draw_x, draw_y;
  logic       is_fighter;
  logic [9:0] fighter_x, fighter_y;
  logic       airborne;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_x, m_y, m_vel;
  bit m_air, m_armed, m_dj;

  fighter_motion dut (
    .Clk        (clk),
    .Reset      (rst),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .is_fighter (is_fighter),
    .Fighter_X  (fighter_x),
    .Fighter_Y  (fighter_y),
    .airborne   (airborne)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_inside(input int dx, input int dy);
    return (dx >= m_x && dx < m_x + 32 && dy >= m_y && dy < m_y + 48) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_x = 100; m_y = 332; m_vel = 0; m_air = 0; m_armed = 1; m_dj = 0;
  endtask

  // One frame of the game rules applied to the model.
  task automatic model_step(input logic [7:0] key);
    bit jump;
    jump = (key == 8'h1A);
    if (key == 8'h04)      m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    else if (key == 8'h07) m_x = (m_x + 2 > 608) ? 608 : m_x + 2;
    if (!m_air) begin
      if (jump && m_armed) begin
        m_air = 1; m_vel = 12; m_armed = 0;
      end
    end
`ifdef FIGHTER_DOUBLE_JUMP_EN
    else if (jump && m_armed && !m_dj) begin
      m_vel = 12; m_dj = 1; m_armed = 0;
    end
`endif
    else if (m_vel > 0) begin
      if (m_y - m_vel < 0) begin
        m_y = 0; m_vel = 0;
      end else begin
        m_y = m_y - m_vel;
        m_vel = m_vel - 1;
      end
    end else begin
      m_vel = (m_vel - 1 < -15) ? -15 : m_vel - 1;
      m_y = m_y - m_vel;
      if (m_y >= 332) begin
        m_y = 332; m_vel = 0; m_air = 0; m_dj = 0;
      end
    end
    if (!jump) m_armed = 1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"}, int'(fighter_x), m_x);
    check({tag, ".y"}, int'(fighter_y), m_y);
    check({tag, ".air"}, int'(airborne), int'(m_air));
    check({tag, ".hit"}, int'(is_fighter), model_inside(int'(draw_x), int'(draw_y)));
  endtask

  // One frame with the given key; outputs sampled on a falling Clk edge.
  task automatic frame(input logic [7:0] key, input string tag);
    @(negedge clk);
    keycode   = key;
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    model_step(key);
    check_all(tag);
  endtask

  logic [7:0] keys [5] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h33};

  initial begin
    rst = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    draw_x = 10'd0; draw_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Sprite box boundaries at the reset position.
    draw_x = 10'd131; draw_y = 10'd379; #1 check("box_in_corner", int'(is_fighter), 1);
    draw_x = 10'd132; draw_y = 10'd379; #1 check("box_right_edge", int'(is_fighter), 0);
    draw_x = 10'd131; draw_y = 10'd380; #1 check("box_bottom_edge", int'(is_fighter), 0);
    draw_x = 10'd100; draw_y = 10'd332; #1 check("box_top_left", int'(is_fighter), 1);
    draw_x = 10'd99;  draw_y = 10'd340; #1 check("box_left_edge", int'(is_fighter), 0);
    draw_x = 10'd110; draw_y = 10'd331; #1 check("box_top_edge", int'(is_fighter), 0);
    draw_x = 10'd110; draw_y = 10'd340;

    // Held jump key: full arc, then no relaunch while still held.
    for (int i = 1; i <= 25; i++) begin
      frame(8'h1A, "jump");
      if (i == 1)  check("jump_t1_air", int'(airborne), 1);
      if (i == 13) check("jump_apex_y", int'(fighter_y), 254);
      if (i == 25) check("jump_land_y", int'(fighter_y), 332);
    end
    check("jump_landed", int'(airborne), 0);
    for (int i = 0; i < 5; i++) frame(8'h1A, "held");
    check("held_no_relaunch", int'(airborne), 0);
    frame(8'h00, "release");
    frame(8'h1A, "repress");
    check("repress_launch", int'(airborne), 1);
    frame(8'h1A, "rise");

    // Asynchronous reset mid-rise takes effect without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_x", int'(fighter_x), 100);
    check("async_rst_y", int'(fighter_y), 332);
    check("async_rst_air", int'(airborne), 0);
    @(negedge clk);
    rst = 1'b0;

    // Walk right to the clamp, then left to zero.
    for (int i = 0; i < 300; i++) frame(8'h07, "walk_r");
    check("clamp_right", int'(fighter_x), 608);
    for (int i = 0; i < 310; i++) frame(8'h04, "walk_l");
    check("clamp_left", int'(fighter_x), 0);

    // A long frame_clk high gives one update; no edge gives none.
    @(negedge clk);
    keycode = 8'h07;
    frame_clk = 1'b1;
    repeat (100) @(negedge clk);
    model_step(8'h07);
    check("long_high_one_step", int'(fighter_x), m_x);
    frame_clk = 1'b0;
    repeat (100) @(negedge clk);
    check("no_edge_no_step", int'(fighter_x), m_x);

    // Randomized keys held for random runs, random beam positions near the sprite.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] k;
      int run;
      k = keys[$urandom_range(0, 4)];
      run = $urandom_range(1, 10);
      for (int j = 0; j < run; j++) begin
        draw_x = 10'(m_x + $urandom_range(0, 40) - 4);
        draw_y = 10'(m_y + $urandom_range(0, 56) - 4);
        frame(k, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
